cordic_vectoring: RTL and testbench



---
 rtl/cordic_vectoring.sv | 174 +++++++++++++++++
 tb/tb_cordic_vectoring.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring.sv
// Vectoring-mode CORDIC: iterative atan2 and gain-compensated magnitude of a
// signed 2.16 Cartesian vector, one micro-rotation per clock.
module cordic_vectoring #(
  parameter int W  = 18,
  parameter int N  = 16,
  parameter int GW = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init,
  input  logic [W-1:0]        x_in,
  input  logic [W-1:0]        y_in,
  output logic [W:0]          angle_out,
  output logic [W-1:0]        mag_out,
  output logic                done
);

  localparam int unsigned IW = W + GW;
  localparam int unsigned ZW = W + 1;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = IW + 17;
  localparam int          KINV    = 39797;
  localparam int          HALF_PI = 102944;
  localparam int          MAG_MAX = (2 ** (W - 1)) - 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ITER  = 3'd2;
  localparam logic [2:0] S_SCALE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]           state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [W-1:0]         x_cap, y_cap;
  logic signed [IW-1:0] x_r, y_r;
  logic signed [ZW-1:0] z_r;
  logic                 zero_r;

  logic signed [IW-1:0] x_ext_c, y_ext_c;
  logic signed [IW-1:0] x_fold_c, y_fold_c;
  logic signed [ZW-1:0] z_fold_c;
  logic signed [IW-1:0] x_sh_c, y_sh_c;
  logic signed [ZW-1:0] atan_c;
  logic signed [PW-1:0] prod_c;
  logic signed [PW-1:0] mag_full_c;
  logic [W-1:0]         mag_c;
  logic                 last_iter_c;

  // Arctangent table, round(atan(2^-i) * 65536)
  function automatic logic signed [ZW-1:0] atan_lut(input logic [CW-1:0] i);
    case (int'(i))
      0:       atan_lut = ZW'(51472);
      1:       atan_lut = ZW'(30386);
      2:       atan_lut = ZW'(16055);
      3:       atan_lut = ZW'(8150);
      4:       atan_lut = ZW'(4091);
      5:       atan_lut = ZW'(2047);
      6:       atan_lut = ZW'(1024);
      7:       atan_lut = ZW'(512);
      8:       atan_lut = ZW'(256);
      9:       atan_lut = ZW'(128);
      10:      atan_lut = ZW'(64);
      11:      atan_lut = ZW'(32);
      12:      atan_lut = ZW'(16);
      13:      atan_lut = ZW'(8);
      14:      atan_lut = ZW'(4);
      15:      atan_lut = ZW'(2);
      default: atan_lut = ZW'(0);
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; init anywhere restarts from LOAD
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_IDLE;
      S_LOAD:  state_nxt = S_ITER;
      S_ITER:  state_nxt = last_iter_c ? S_SCALE : S_ITER;
      S_SCALE: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
    if (init) state_nxt = S_LOAD;
  end

  // Sign extension and quadrant fold into the right half-plane
  always_comb begin
    x_ext_c  = {{GW{x_cap[W-1]}}, x_cap};
    y_ext_c  = {{GW{y_cap[W-1]}}, y_cap};
    x_fold_c = x_ext_c;
    y_fold_c = y_ext_c;
    z_fold_c = '0;
    if (x_ext_c < 0) begin
      if (y_ext_c >= 0) begin
        x_fold_c = y_ext_c;
        y_fold_c = -x_ext_c;
        z_fold_c = ZW'(HALF_PI);
      end else begin
        x_fold_c = -y_ext_c;
        y_fold_c = x_ext_c;
        z_fold_c = -ZW'(HALF_PI);
      end
    end
  end

  // Micro-rotation operands and gain-compensated, saturated magnitude
  always_comb begin
    x_sh_c      = x_r >>> cnt;
    y_sh_c      = y_r >>> cnt;
    atan_c      = atan_lut(cnt);
    last_iter_c = (cnt == CW'(N - 1));
    prod_c      = PW'(x_r) * PW'(KINV);
    mag_full_c  = (prod_c + PW'(32768)) >>> 16;
    mag_c       = W'(mag_full_c);
    if (mag_full_c > PW'(MAG_MAX)) mag_c = W'(MAG_MAX);
    else if (mag_full_c < 0)       mag_c = '0;
  end

  // Input capture, iteration datapath and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cap  <= '0;
      y_cap  <= '0;
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
      zero_r <= 1'b0;
      cnt    <= '0;
    end else if (init) begin
      x_cap <= x_in;
      y_cap <= y_in;
      cnt   <= '0;
    end else if (state == S_LOAD) begin
      x_r    <= x_fold_c;
      y_r    <= y_fold_c;
      z_r    <= z_fold_c;
      zero_r <= (x_cap == '0) && (y_cap == '0);
      cnt    <= '0;
    end else if (state == S_ITER) begin
      if (y_r >= 0) begin
        x_r <= x_r + y_sh_c;
        y_r <= y_r - x_sh_c;
        z_r <= z_r + atan_c;
      end else begin
        x_r <= x_r - y_sh_c;
        y_r <= y_r + x_sh_c;
        z_r <= z_r - atan_c;
      end
      if (!last_iter_c) cnt <= cnt + CW'(1);
    end
  end

  // Registered results and done flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle_out <= '0;
      mag_out   <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state_nxt == S_DONE);
      if (state == S_SCALE && !init) begin
        angle_out <= zero_r ? '0 : z_r;
        mag_out   <= zero_r ? '0 : mag_c;
      end
    end
  end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring: latency, angle/magnitude accuracy,
// quadrant folding, zero vector, saturation, restart and async reset.
module tb_cordic_vectoring;

  localparam int W = 18;
  localparam int N = 16;
  localparam int LAT = N + 2;

  logic         clk;
  logic         rst_n;
  logic         init;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic [W:0]   angle_out;
  logic [W-1:0] mag_out;
  logic         done;

  int n_chk  = 0;
  int n_pass = 0;

  cordic_vectoring #(.W(W), .N(N), .GW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (init),
    .x_in      (x_in),
    .y_in      (y_in),
    .angle_out (angle_out),
    .mag_out   (mag_out),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare observed against expected within +/- tol
  task automatic check(input string tag, input int got, input int exp, input int tol);
    n_chk++;
    if (got >= exp - tol && got <= exp + tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (+/-%0d)", tag, got, exp, tol);
  endtask

  function automatic int ang();
    return int'($signed(angle_out));
  endfunction

  function automatic int mag();
    return int'($signed(mag_out));
  endfunction

  // Pulse init for one edge with the given vector, then scramble the inputs
  task automatic start(input int xi, input int yi);
    @(negedge clk);
    x_in = W'(xi);
    y_in = W'(yi);
    init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    x_in = W'(32'h1_5555);
    y_in = W'(32'h2_AAAA);
  endtask

  // Count edges until done, bounded
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 4 * LAT) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, n, LAT, 0);
  endtask

  task automatic run(input string tag, input int xi, input int yi,
                     input int ea, input int ta, input int em, input int tm);
    start(xi, yi);
    check({tag, "_done_drop"}, int'(done), 0, 0);
    wait_done(tag);
    check({tag, "_ang"}, ang(), ea, ta);
    check({tag, "_mag"}, mag(), em, tm);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_hold"}, int'(done), 1, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    init  = 1'b0;
    x_in  = '0;
    y_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", int'(done), 0, 0);
    check("rst_ang", ang(), 0, 0);
    check("rst_mag", mag(), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run("x1",     65536,      0,       0, 4, 65536, 4);
    run("y1",         0,  65536,  102944, 4, 65536, 4);
    run("ym1",        0, -65536, -102944, 4, 65536, 4);
    run("pi4",    46341,  46341,   51472, 4, 65536, 4);
    run("pi8",    60546,  25081,   25736, 4, 65536, 4);
    run("pi",    -65536,      0,  205887, 4, 65536, 4);
    run("m3pi4", -46341, -46341, -154416, 4, 65536, 4);
    run("zero",       0,      0,       0, 0,     0, 0);
    run("sat",   131071, 131071,   51472, 4, 131071, 0);

    // Restart partway through iterating: results follow the second vector
    start(65536, 0);
    repeat (8) @(posedge clk);
    #1;
    check("rs_busy", int'(done), 0, 0);
    start(0, 65536);
    wait_done("rs");
    check("rs_ang", ang(), 102944, 4);
    check("rs_mag", mag(), 65536, 4);

    // Async reset mid-iteration clears outputs and suppresses done
    start(46341, 46341);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_done", int'(done), 0, 0);
    check("ar_ang", ang(), 0, 0);
    check("ar_mag", mag(), 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 6) @(posedge clk);
    #1;
    check("ar_idle_done", int'(done), 0, 0);
    check("ar_idle_ang", ang(), 0, 0);
    check("ar_idle_mag", mag(), 0, 0);

    run("post", 60546, 25081, 25736, 4, 65536, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
